// File: rtl/sla_pkg.sv
// Shared types and constants for the serial link arbiter: FSM state encoding,
// default frame geometry and index widths.
package sla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } sla_state_t;

    localparam int FRAME_BITS_DEF = 21;
    localparam int GAP_CYCLES_DEF = 1;
    localparam int BIT_IDX_W      = 5;
    localparam int FRAME_IDX_W    = 4;
    localparam int GAP_CNT_W      = 3;
    localparam int REM_W          = 4;

    // A request for zero frames still gets one frame on the bus.
    function automatic logic [REM_W-1:0] sla_load_count(input logic [REM_W-1:0] n);
        return (n == '0) ? REM_W'(1) : n;
    endfunction

endpackage

// File: rtl/sla_rr_pick.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the requester that did not own the bus last.
module sla_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_pick,
    output logic       o_valid
);

    always_comb begin
        o_pick = 1'b0;
        case (i_req)
            2'b10:   o_pick = 1'b1;
            2'b11:   o_pick = ~i_last_owner;
            default: o_pick = 1'b0;
        endcase
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/serial_link_arbiter.sv
// Owner arbitration and frame sequencing (SETUP, XFER bit slots, GAP) for the
// shared half-duplex serial link. Define SLA_INTERLEAVE_EN to let a waiting
// requester take the bus between frames, with the yielding burst resumed later.
module serial_link_arbiter
    import sla_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_0,
    input  logic                   req_1,
    input  logic [REM_W-1:0]       nframes_0,
    input  logic [REM_W-1:0]       nframes_1,
    output logic                   gnt_0,
    output logic                   gnt_1,
    output logic                   sen_n,
    output logic [BIT_IDX_W-1:0]   bit_idx,
    output logic [FRAME_IDX_W-1:0] frame_idx,
    output logic                   frame_start,
    output logic                   done_0,
    output logic                   done_1,
    output logic                   abort,
    output logic                   busy
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'(GAP_CYCLES - 1);

    sla_state_t             r_state;
    logic                   r_owner;
    logic                   r_last_owner;
    logic [REM_W-1:0]       r_rem;
    logic [BIT_IDX_W-1:0]   r_bit;
    logic [GAP_CNT_W-1:0]   r_gap;
    logic [FRAME_IDX_W-1:0] r_fidx;
    logic                   r_drop;
    logic [1:0]             r_gnt;
    logic                   r_sen_n;
    logic                   r_fstart;
    logic [1:0]             r_done;
    logic                   r_abort;
    logic                   r_busy;

`ifdef SLA_INTERLEAVE_EN
    logic [REM_W-1:0]       r_save_rem  [2];
    logic [FRAME_IDX_W-1:0] r_save_fidx [2];
    logic [1:0]             r_save_vld;
    logic                   w_other_req;
`endif

    logic             w_pick;
    logic             w_pick_valid;
    logic [REM_W-1:0] w_pick_nframes;
    logic             w_owner_req;
    logic             w_drop_now;

    sla_rr_pick u_pick (
        .i_req        ({req_1, req_0}),
        .i_last_owner (r_last_owner),
        .o_pick       (w_pick),
        .o_valid      (w_pick_valid)
    );

    assign w_pick_nframes = w_pick ? nframes_1 : nframes_0;
    assign w_owner_req    = r_owner ? req_1 : req_0;
    // A request dropped at any point in the burst ends it after the current frame.
    assign w_drop_now     = r_drop | ~w_owner_req;
`ifdef SLA_INTERLEAVE_EN
    assign w_other_req    = r_owner ? req_0 : req_1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_rem        <= '0;
            r_bit        <= '0;
            r_gap        <= '0;
            r_fidx       <= '0;
            r_drop       <= 1'b0;
            r_gnt        <= 2'b00;
            r_sen_n      <= 1'b1;
            r_fstart     <= 1'b0;
            r_done       <= 2'b00;
            r_abort      <= 1'b0;
            r_busy       <= 1'b0;
`ifdef SLA_INTERLEAVE_EN
            for (int i = 0; i < 2; i++) begin
                r_save_rem[i]  <= '0;
                r_save_fidx[i] <= '0;
            end
            r_save_vld   <= 2'b00;
`endif
        end else begin
            r_fstart <= 1'b0;
            r_done   <= 2'b00;
            r_abort  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= ST_SETUP;
                        r_owner <= w_pick;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_drop  <= 1'b0;
`ifdef SLA_INTERLEAVE_EN
                        if (r_save_vld[w_pick]) begin
                            r_rem              <= r_save_rem[w_pick];
                            r_fidx             <= r_save_fidx[w_pick];
                            r_save_vld[w_pick] <= 1'b0;
                        end else begin
                            r_rem  <= sla_load_count(w_pick_nframes);
                            r_fidx <= '0;
                        end
`else
                        r_rem  <= sla_load_count(w_pick_nframes);
                        r_fidx <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    r_state  <= ST_XFER;
                    r_sen_n  <= 1'b0;
                    r_bit    <= '0;
                    r_fstart <= 1'b1;
                    if (!w_owner_req) r_drop <= 1'b1;
                end
                ST_XFER: begin
                    if (!w_owner_req) r_drop <= 1'b1;
                    if (r_bit == LAST_BIT) begin
                        r_state <= ST_GAP;
                        r_sen_n <= 1'b1;
                        r_bit   <= '0;
                        r_gap   <= '0;
                        r_rem   <= r_rem - REM_W'(1);
                    end else begin
                        r_bit <= r_bit + BIT_IDX_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap != LAST_GAP) begin
                        r_gap <= r_gap + GAP_CNT_W'(1);
                        if (!w_owner_req) r_drop <= 1'b1;
                    end else if (r_rem != '0 && !w_drop_now) begin
`ifdef SLA_INTERLEAVE_EN
                        if (w_other_req) begin
                            // Yield without done; the burst resumes on the next grant.
                            r_state              <= ST_IDLE;
                            r_gnt                <= 2'b00;
                            r_busy               <= 1'b0;
                            r_last_owner         <= r_owner;
                            r_save_rem[r_owner]  <= r_rem;
                            r_save_fidx[r_owner] <= r_fidx + FRAME_IDX_W'(1);
                            r_save_vld[r_owner]  <= 1'b1;
                            r_rem                <= '0;
                            r_fidx               <= '0;
                        end else begin
                            r_state  <= ST_XFER;
                            r_sen_n  <= 1'b0;
                            r_fstart <= 1'b1;
                            r_fidx   <= r_fidx + FRAME_IDX_W'(1);
                        end
`else
                        r_state  <= ST_XFER;
                        r_sen_n  <= 1'b0;
                        r_fstart <= 1'b1;
                        r_fidx   <= r_fidx + FRAME_IDX_W'(1);
`endif
                    end else begin
                        r_state         <= ST_IDLE;
                        r_gnt           <= 2'b00;
                        r_busy          <= 1'b0;
                        r_done[r_owner] <= 1'b1;
                        r_abort         <= (r_rem != '0);
                        r_rem           <= '0;
                        r_fidx          <= '0;
                        r_last_owner    <= r_owner;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_0       = r_gnt[0];
    assign gnt_1       = r_gnt[1];
    assign sen_n       = r_sen_n;
    assign bit_idx     = r_bit;
    assign frame_idx   = r_fidx;
    assign frame_start = r_fstart;
    assign done_0      = r_done[0];
    assign done_1      = r_done[1];
    assign abort       = r_abort;
    assign busy        = r_busy;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Self-checking bench for serial_link_arbiter (default build): expected bursts
// are queued when requests are raised and checked when done_x pulses.
module tb_serial_link_arbiter;

    localparam int FB        = 21;
    localparam int GAPC      = 1;
    localparam int FRAME_CYC = FB + GAPC;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_0, req_1;
    logic [3:0] nframes_0, nframes_1;
    logic       gnt_0, gnt_1, sen_n, frame_start, done_0, done_1, abort, busy;
    logic [4:0] bit_idx;
    logic [3:0] frame_idx;

    serial_link_arbiter #(
        .FRAME_BITS (FB),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_0       (req_0),
        .req_1       (req_1),
        .nframes_0   (nframes_0),
        .nframes_1   (nframes_1),
        .gnt_0       (gnt_0),
        .gnt_1       (gnt_1),
        .sen_n       (sen_n),
        .bit_idx     (bit_idx),
        .frame_idx   (frame_idx),
        .frame_start (frame_start),
        .done_0      (done_0),
        .done_1      (done_1),
        .abort       (abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;
        int frames;
        int abrt;
        int gcyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int o, input int f, input int a);
        exp_t e;
        e.owner  = o;
        e.frames = f;
        e.abrt   = a;
        e.gcyc   = 1 + f * FRAME_CYC;
        return e;
    endfunction

    // Monitor: per-frame checks on frame_start, per-burst checks on done.
    int   m_gcyc = 0, m_low = 0, m_fs = 0, m_since = 0, m_both = 0;
    exp_t m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_gcyc = 0; m_low = 0; m_fs = 0; m_since = 0; m_both = 0;
        end else begin
            if (gnt_0 || gnt_1) m_gcyc++;
            if (gnt_0 && gnt_1) m_both++;
            if (!sen_n) m_low++;
            m_since++;
            if (frame_start) begin
                check("fs_frame_idx", int'(frame_idx), m_fs);
                check("fs_bit_idx", int'(bit_idx), 0);
                if (m_fs > 0) check("fs_spacing", m_since, FRAME_CYC);
                m_since = 0;
                m_fs++;
            end
            if (done_0 || done_1) begin
                check("done_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                check("done_onehot", int'(done_0) + int'(done_1), 1);
                check("gnt_low_at_done", int'(gnt_0 | gnt_1), 0);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    check("done_owner", done_1 ? 1 : 0, m_e.owner);
                    check("done_abort", int'(abort), m_e.abrt);
                    check("burst_frames", m_fs, m_e.frames);
                    check("grant_cycles", m_gcyc, m_e.gcyc);
                    check("sen_low_cycles", m_low, m_e.frames * FB);
                    check("double_grant", m_both, 0);
                end
                $display("TXN owner=%0d frames=%0d abort=%0d grant_cycles=%0d sen_low=%0d",
                         done_1 ? 1 : 0, m_fs, abort, m_gcyc, m_low);
                m_gcyc = 0; m_low = 0; m_fs = 0; m_both = 0;
            end
        end
    end

    task automatic wait_done(output int who, input int budget);
        who = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_0 || done_1) begin
                who = done_1 ? 1 : 0;
                break;
            end
        end
        check("done_seen", (who >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int who;
        int found;
        rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0; nframes_0 = 4'd0; nframes_1 = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_gnt_0", int'(gnt_0), 0);
        check("rst_gnt_1", int'(gnt_1), 0);
        check("rst_sen_n", int'(sen_n), 1);
        check("rst_bit_idx", int'(bit_idx), 0);
        check("rst_frame_idx", int'(frame_idx), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_done", int'(done_0 | done_1), 0);
        check("rst_abort", int'(abort), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Single frame from requester 0
        @(posedge clk); #1;
        nframes_0 = 4'd1; req_0 = 1'b1;
        exp_q.push_back(mk(0, 1, 0));
        @(posedge clk); #1;
        check("gnt_latency", int'(gnt_0), 1);
        check("gnt_other_low", int'(gnt_1), 0);
        check("busy_setup", int'(busy), 1);
        check("sen_high_setup", int'(sen_n), 1);
        @(posedge clk); #1;
        check("sen_low_xfer", int'(sen_n), 0);
        check("frame_start_0", int'(frame_start), 1);
        wait_done(who, 100);
        check("single_owner", who, 0);
        req_0 = 1'b0;

        // Eight-frame burst from requester 1
        @(negedge clk);
        nframes_1 = 4'd8; req_1 = 1'b1;
        exp_q.push_back(mk(1, 8, 0));
        wait_done(who, 400);
        check("burst_owner", who, 1);
        req_1 = 1'b0;

        // Both requesting straight out of reset; nframes_0=0 counts as one frame
        @(negedge clk);
        rst = 1'b1; nframes_0 = 4'd0; nframes_1 = 4'd2; req_0 = 1'b1; req_1 = 1'b1;
        exp_q.push_back(mk(0, 1, 0));
        exp_q.push_back(mk(1, 2, 0));
        exp_q.push_back(mk(0, 1, 0));
        @(negedge clk);
        rst = 1'b0;
        wait_done(who, 100);
        check("rr_first", who, 0);
        wait_done(who, 200);
        check("rr_second", who, 1);
        req_1 = 1'b0;
        wait_done(who, 100);
        check("rr_third", who, 0);
        req_0 = 1'b0;

        // Requester 0 drops out at bit 5 of frame 2 of a 4-frame burst
        @(negedge clk);
        nframes_0 = 4'd4; req_0 = 1'b1;
        exp_q.push_back(mk(0, 3, 1));
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (frame_idx == 4'd2 && bit_idx == 5'd5 && !sen_n) found = 1;
        end
        check("abort_point", found, 1);
        req_0 = 1'b0;
        wait_done(who, 100);
        check("abort_owner", who, 0);

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        nframes_1 = 4'd2; req_1 = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (bit_idx == 5'd10 && !sen_n) found = 1;
        end
        check("rst_point", found, 1);
        rst = 1'b1;
        #1;
        check("midrst_sen_n", int'(sen_n), 1);
        check("midrst_gnt_1", int'(gnt_1), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done_1), 0);
        req_1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        nframes_1 = 4'd1; req_1 = 1'b1;
        exp_q.push_back(mk(1, 1, 0));
        wait_done(who, 100);
        check("post_rst_owner", who, 1);
        req_1 = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
